// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Purpose  : Shared command codes, FSM states and per-quarter bus levels for
//            the I2C bit-level transmit engine.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  localparam logic [2:0] CMD_START  = 3'b001;
  localparam logic [2:0] CMD_WRITE8 = 3'b011;
  localparam logic [2:0] CMD_STOP   = 3'b100;
  localparam logic [2:0] CMD_NACK   = 3'b101;
  localparam logic [2:0] CMD_ACK    = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] QTR_0 = 2'd0;
  localparam logic [1:0] QTR_1 = 2'd1;
  localparam logic [1:0] QTR_2 = 2'd2;
  localparam logic [1:0] QTR_3 = 2'd3;

  function automatic logic cmd_is_valid(input logic [2:0] cmd);
    return (cmd == CMD_START) || (cmd == CMD_WRITE8) || (cmd == CMD_STOP) ||
           (cmd == CMD_NACK)  || (cmd == CMD_ACK);
  endfunction

  function automatic logic cmd_is_data(input logic [2:0] cmd);
    return (cmd == CMD_WRITE8) || (cmd == CMD_NACK) || (cmd == CMD_ACK);
  endfunction

  // {scl, sda} for a quarter; data commands keep sda, the bit is loaded separately.
  function automatic logic [1:0] bus_level(input logic [2:0] cmd, input logic [1:0] qtr,
                                           input logic scl_now, input logic sda_now);
    logic [1:0] lv;
    lv = {1'b0, sda_now};
    case (cmd)
      CMD_START: begin
        case (qtr)
          QTR_0:   lv = {scl_now, 1'b1};
          QTR_1:   lv = 2'b11;
          QTR_2:   lv = 2'b10;
          default: lv = 2'b00;
        endcase
      end
      CMD_STOP: begin
        case (qtr)
          QTR_0:   lv = 2'b00;
          QTR_1:   lv = 2'b10;
          default: lv = 2'b11;
        endcase
      end
      default: lv = {(qtr == QTR_1) || (qtr == QTR_2), sda_now};
    endcase
    return lv;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_write_byte_qtick.sv
`default_nettype none
// ============================================================================
// Module   : i2c_qtick
// Purpose  : Quarter-bit divider: QDIV clocks per quarter, 2-bit quarter index,
//            restartable at the start of each bus command.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_qtick
  import i2c_pkg::*;
#(
  parameter int QDIV = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       restart,
  input  logic       enable,
  output logic       tick,
  output logic       pre_tick,
  output logic       first,
  output logic [1:0] quarter
);

  localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(QDIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_qtr;

  assign tick    = (r_cnt == C_CNT_LAST);
  assign first   = (r_cnt == '0);
  assign quarter = r_qtr;

  // pre_tick: the following clock is the last one of the current quarter.
  generate
    if (QDIV == 1) begin : g_single
      assign pre_tick = 1'b1;
    end else begin : g_multi
      assign pre_tick = (r_cnt == CW'(QDIV - 2));
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_qtr <= QTR_0;
    end else if (restart) begin
      r_cnt <= '0;
      r_qtr <= QTR_0;
    end else if (enable) begin
      if (tick) begin
        r_cnt <= '0;
        r_qtr <= r_qtr + 2'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_write_byte.sv
`default_nettype none
// ============================================================================
// Module   : i2c_write_byte
// Purpose  : Bit-level I2C master transmit engine (START/STOP/ACK/NACK/WRITE8).
//            Optional busy output when I2C_WB_BUSY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_write_byte
  import i2c_pkg::*;
#(
  parameter int QDIV = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       go,
  input  logic [2:0] command,
  input  logic       data,
  output logic       load,
  output logic       finish,
  output logic       scl,
  output logic       sda
`ifdef I2C_WB_BUSY_EN
  ,
  output logic       busy
`endif
);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cmd, r_slot, w_last_slot;
  logic       r_scl, r_sda, r_load, r_finish;
  logic       w_scl_nxt, w_sda_nxt, w_load_nxt, w_finish_nxt;
  logic       w_tick, w_pre_tick, w_first;
  logic [1:0] w_qtr, w_qtr_up;
  logic       w_restart, w_enable, w_run_end, w_sample;

  assign w_restart   = (r_state == S_IDLE) && go;
  assign w_enable    = (r_state == S_RUN);
  assign w_qtr_up    = w_tick ? (w_qtr + 2'd1) : w_qtr;
  assign w_last_slot = (r_cmd == CMD_WRITE8) ? 3'd7 : 3'd0;
  assign w_run_end   = w_enable && w_tick && (w_qtr == QTR_3) && (r_slot == w_last_slot);
  // Bit is taken at the end of the first Q0 clock, after the shifter has advanced.
  assign w_sample    = w_enable && w_first && (w_qtr == QTR_0) && cmd_is_data(r_cmd);

  i2c_qtick #(.QDIV(QDIV)) u_qtick (
    .clock    (clock),
    .reset_n  (reset_n),
    .restart  (w_restart),
    .enable   (w_enable),
    .tick     (w_tick),
    .pre_tick (w_pre_tick),
    .first    (w_first),
    .quarter  (w_qtr)
  );

  // Outputs are registered, so levels are computed for the upcoming quarter.
  always_comb begin
    w_state_nxt = r_state;
    w_scl_nxt   = r_scl;
    w_sda_nxt   = r_sda;
    w_load_nxt  = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        if (go) begin
          if (cmd_is_valid(command)) begin
            w_state_nxt            = S_RUN;
            {w_scl_nxt, w_sda_nxt} = bus_level(command, QTR_0, r_scl, r_sda);
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (w_run_end) begin
          w_state_nxt = S_DONE;
        end else begin
          {w_scl_nxt, w_sda_nxt} = bus_level(r_cmd, w_qtr_up, r_scl, r_sda);
          if (w_sample) begin
            w_sda_nxt = (r_cmd == CMD_WRITE8) ? data : (r_cmd == CMD_NACK);
          end
          if ((r_cmd == CMD_WRITE8) && (w_qtr_up == QTR_3) && w_pre_tick) begin
            w_load_nxt = 1'b0;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_finish_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cmd    <= 3'd0;
      r_slot   <= 3'd0;
      r_scl    <= 1'b1;
      r_sda    <= 1'b1;
      r_load   <= 1'b1;
      r_finish <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_scl    <= w_scl_nxt;
      r_sda    <= w_sda_nxt;
      r_load   <= w_load_nxt;
      r_finish <= w_finish_nxt;
      if (w_restart) begin
        r_cmd  <= command;
        r_slot <= 3'd0;
      end else if (w_enable && w_tick && (w_qtr == QTR_3)) begin
        r_slot <= r_slot + 3'd1;
      end
    end
  end

  assign scl    = r_scl;
  assign sda    = r_sda;
  assign load   = r_load;
  assign finish = r_finish;

`ifdef I2C_WB_BUSY_EN
  assign busy = (r_state != S_IDLE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_write_byte.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_write_byte
// Purpose  : Self-checking bench for i2c_write_byte with an external shifter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_write_byte;

  typedef struct {
    logic [2:0] cmd;
    logic [7:0] dat;
    int         lat;
    int         nbits;
    logic [7:0] bits;
    int         nstart;
    int         nstop;
    int         nload;
    logic       fscl;
    logic       fsda;
    logic       drop_early;
  } vec_t;

  logic       clock, reset_n, go, data, load, finish, scl, sda;
  logic [2:0] command;
  logic [7:0] sh, pre_val;
  logic       pre_req;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[11];
  vec_t exp_q[$];

  i2c_write_byte #(.QDIV(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .go      (go),
    .command (command),
    .data    (data),
    .load    (load),
    .finish  (finish),
    .scl     (scl),
    .sda     (sda)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External shift register feeding data MSB first, advanced by the load strobe.
  assign data = sh[7];
  always @(posedge clock) begin
    if (pre_req)    sh <= pre_val;
    else if (!load) sh <= {sh[6:0], 1'b0};
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] cmd, input logic [7:0] dat, input int lat,
                              input int nbits, input logic [7:0] bits, input int nstart,
                              input int nstop, input int nload, input logic fscl,
                              input logic fsda, input logic drop_early);
    vec_t v;
    v.cmd = cmd; v.dat = dat; v.lat = lat; v.nbits = nbits; v.bits = bits;
    v.nstart = nstart; v.nstop = nstop; v.nload = nload;
    v.fscl = fscl; v.fsda = fsda; v.drop_early = drop_early;
    return v;
  endfunction

  // Bus monitor: collects bits, START/STOP edges, load pulses and latency per op.
  initial begin
    int         cyc = 0, nbits = 0, nstart = 0, nstop = 0, nload = 0, nload_edge = 0;
    logic [7:0] bits = 8'd0;
    logic       active = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1, prev_load = 1'b1;
    vec_t       e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        active = 1'b0; cyc = 0; nbits = 0; bits = 8'd0;
        nstart = 0; nstop = 0; nload = 0; nload_edge = 0;
      end else begin
        if (!active && go) begin
          active = 1'b1;
          cyc    = 1;
        end else if (active) begin
          cyc++;
        end
        if (!prev_scl && scl) begin
          bits = {bits[6:0], sda};
          nbits++;
        end
        if (prev_scl && scl && (sda != prev_sda)) begin
          if (sda) nstop++;
          else     nstart++;
        end
        if (!load) begin
          nload++;
          if (prev_load) nload_edge++;
        end
        if (finish) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_finish: actual=1 expected=0");
          end else begin
            e = exp_q.pop_front();
            check($sformatf("latency cmd=%0d", e.cmd), cyc, e.lat);
            check($sformatf("nbits cmd=%0d", e.cmd), nbits, e.nbits);
            check($sformatf("bits cmd=%0d", e.cmd), int'(bits), int'(e.bits));
            check($sformatf("start_edges cmd=%0d", e.cmd), nstart, e.nstart);
            check($sformatf("stop_edges cmd=%0d", e.cmd), nstop, e.nstop);
            check($sformatf("load_low_clocks cmd=%0d", e.cmd), nload, e.nload);
            check($sformatf("load_pulses cmd=%0d", e.cmd), nload_edge, e.nload);
            check($sformatf("final_scl cmd=%0d", e.cmd), int'(scl), int'(e.fscl));
            check($sformatf("final_sda cmd=%0d", e.cmd), int'(sda), int'(e.fsda));
          end
          active = 1'b0; cyc = 0; nbits = 0; bits = 8'd0;
          nstart = 0; nstop = 0; nload = 0; nload_edge = 0;
        end
      end
      prev_scl  = scl;
      prev_sda  = sda;
      prev_load = load;
    end
  end

  task automatic preload(input logic [7:0] v);
    pre_val = v;
    pre_req = 1'b1;
    @(posedge clock); #1;
    pre_req = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    bit got = 0;
    preload(v.dat);
    exp_q.push_back(v);
    go      = 1'b1;
    command = v.cmd;
    for (int n = 0; n < 300; n++) begin
      @(posedge clock); #1;
      if (v.drop_early && n == 4) begin
        go      = 1'b0;
        command = 3'b110;
      end
      if (finish) begin
        got = 1;
        break;
      end
    end
    go = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL timeout cmd=%0d: actual=no_finish expected=finish", v.cmd);
    end
    @(posedge clock); #1;
    check($sformatf("finish_one_clock cmd=%0d", v.cmd), int'(finish), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_scl"}, int'(scl), 1);
    check({tag, "_sda"}, int'(sda), 1);
    check({tag, "_load"}, int'(load), 1);
    check({tag, "_finish"}, int'(finish), 0);
  endtask

  initial begin
    bit seen;
    int pulses;
    reset_n = 1'b0; go = 1'b0; command = 3'd0; pre_req = 1'b0; pre_val = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals("reset");
    reset_n = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    check_reset_vals("idle_hold");

    //          cmd     dat    lat nb bits  st sp ld scl sda drop
    vecs[0]  = mk(3'b001, 8'h00, 18, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(3'b011, 8'hAC, 130, 8, 8'hAC, 0, 0, 8, 0, 0, 0);
    vecs[2]  = mk(3'b111, 8'h00, 18, 1, 8'h00, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(3'b101, 8'h00, 18, 1, 8'h01, 0, 0, 0, 0, 1, 0);
    vecs[4]  = mk(3'b001, 8'h00, 18, 1, 8'h01, 1, 0, 0, 0, 0, 0);
    vecs[5]  = mk(3'b011, 8'h35, 130, 8, 8'h35, 0, 0, 8, 0, 1, 1);
    vecs[6]  = mk(3'b100, 8'h00, 18, 1, 8'h00, 0, 1, 0, 1, 1, 0);
    vecs[7]  = mk(3'b000, 8'h00, 2, 0, 8'h00, 0, 0, 0, 1, 1, 0);
    vecs[8]  = mk(3'b101, 8'h00, 18, 1, 8'h01, 0, 0, 0, 0, 1, 0);
    vecs[9]  = mk(3'b100, 8'h00, 18, 1, 8'h00, 0, 1, 0, 1, 1, 0);
    vecs[10] = mk(3'b110, 8'h00, 2, 0, 8'h00, 0, 0, 0, 1, 1, 0);

    foreach (vecs[i]) run_op(vecs[i]);

    // Asynchronous reset in the middle of a byte, during a load-low clock.
    preload(8'h00);
    go      = 1'b1;
    command = 3'b011;
    seen    = 0;
    pulses  = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clock); #1;
      if (!load) begin
        pulses++;
        if (pulses == 2) begin
          seen = 1;
          break;
        end
      end
    end
    check("abort_reached_load_pulse", int'(seen), 1);
    check("abort_pre_scl_low", int'(scl), 0);
    #2;
    reset_n = 1'b0;
    go      = 1'b0;
    #1;
    check_reset_vals("async_reset");
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    run_op(vecs[0]);

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
